// File: rtl/cp0_int_ctrl_if.sv
// Bus bundle between the CP0 pipeline (master) and the Count/Compare/Cause block (slave).
// Carries MTC0 writes, exception commit, interrupt lines, Status input and the register outputs.
interface cp0_int_ctrl_if;
   logic        mtc0_we;
   logic [5:0]  cp0_addr;
   logic [31:0] mtc0_data;
   logic        exception;
   logic [4:0]  exc_code;
   logic        exc_bd;
   logic [5:0]  ext_int;
   logic [31:0] cp0_Status_data;
   logic [31:0] cp0_Count_data;
   logic [31:0] cp0_Compare_data;
   logic [31:0] cp0_Cause_data;
   logic        int_req;

   modport master (
      output mtc0_we, cp0_addr, mtc0_data, exception, exc_code, exc_bd, ext_int, cp0_Status_data,
      input  cp0_Count_data, cp0_Compare_data, cp0_Cause_data, int_req
   );

   modport slave (
      input  mtc0_we, cp0_addr, mtc0_data, exception, exc_code, exc_bd, ext_int, cp0_Status_data,
      output cp0_Count_data, cp0_Compare_data, cp0_Cause_data, int_req
   );
endinterface

// File: rtl/cp0_int_ctrl.sv
// CP0 Count/Compare/Cause registers and registered interrupt-request generator.
// Timer interrupt from Count==Compare on increment; external lines via 2-flop synchronizers.
module cp0_int_ctrl #(
   parameter logic [5:0] ADDR_COUNT   = 6'd9,
   parameter logic [5:0] ADDR_COMPARE = 6'd11,
   parameter logic [5:0] ADDR_CAUSE   = 6'd13,
   parameter int         COUNT_DIV    = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   cp0_int_ctrl_if.slave  bus
);

   localparam int PHASE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(COUNT_DIV - 1);
   localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

   logic [31:0]        count_r;
   logic [31:0]        compare_r;
   logic [PHASE_W-1:0] phase_r;
   logic               ti_r;
   logic               bd_r;
   logic [4:0]         exc_code_r;
   logic [1:0]         sw_ip_r;
   logic [5:0]         sync1_r;
   logic [5:0]         sync2_r;
   logic               int_req_r;

   logic               wr_ok_s;
   logic               wr_count_s;
   logic               wr_compare_s;
   logic               wr_cause_s;
   logic               tick_s;
   logic [31:0]        count_inc_s;
   logic [7:0]         ip_s;
   logic               status_ie_s;
   logic               status_exl_s;
   logic [7:0]         status_im_s;
   logic               unused_status_s;

   // Decode accepted writes (an exception commit blocks every MTC0) and the Count tick.
   always_comb begin
      wr_ok_s         = bus.mtc0_we & ~bus.exception;
      wr_count_s      = wr_ok_s & (bus.cp0_addr == ADDR_COUNT);
      wr_compare_s    = wr_ok_s & (bus.cp0_addr == ADDR_COMPARE);
      wr_cause_s      = wr_ok_s & (bus.cp0_addr == ADDR_CAUSE);
      tick_s          = (phase_r == PHASE_LAST);
      count_inc_s     = count_r + 32'd1;
      ip_s            = {sync2_r[5] | ti_r, sync2_r[4:0], sw_ip_r};
      status_ie_s     = bus.cp0_Status_data[0];
      status_exl_s    = bus.cp0_Status_data[1];
      status_im_s     = bus.cp0_Status_data[15:8];
      unused_status_s = ^{bus.cp0_Status_data[31:16], bus.cp0_Status_data[7:2]};
   end

   // Count, phase divider, Compare and the timer-interrupt flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r   <= 32'd0;
         compare_r <= 32'd0;
         phase_r   <= {PHASE_W{1'b0}};
         ti_r      <= 1'b0;
      end else begin
         if (wr_count_s) begin
            count_r <= bus.mtc0_data;
            phase_r <= {PHASE_W{1'b0}};
         end else if (tick_s) begin
            count_r <= count_inc_s;
            phase_r <= {PHASE_W{1'b0}};
         end else begin
            count_r <= count_r;
            phase_r <= phase_r + PHASE_ONE;
         end
         // A Compare write clears TI even if an increment match lands on the same edge.
         if (wr_compare_s) begin
            compare_r <= bus.mtc0_data;
            ti_r      <= 1'b0;
         end else if (tick_s && !wr_count_s && (count_inc_s == compare_r)) begin
            compare_r <= compare_r;
            ti_r      <= 1'b1;
         end else begin
            compare_r <= compare_r;
            ti_r      <= ti_r;
         end
      end
   end

   // Cause fields, software IP bits and the external-line synchronizers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bd_r       <= 1'b0;
         exc_code_r <= 5'd0;
         sw_ip_r    <= 2'b00;
         sync1_r    <= 6'd0;
         sync2_r    <= 6'd0;
      end else begin
         sync1_r <= bus.ext_int;
         sync2_r <= sync1_r;
         if (bus.exception) begin
            exc_code_r <= bus.exc_code;
            bd_r       <= status_exl_s ? bd_r : bus.exc_bd;
         end else begin
            exc_code_r <= exc_code_r;
            bd_r       <= bd_r;
         end
         if (wr_cause_s) begin
            sw_ip_r <= bus.mtc0_data[9:8];
         end else begin
            sw_ip_r <= sw_ip_r;
         end
      end
   end

   // Level interrupt request, one edge behind IP and Status.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         int_req_r <= 1'b0;
      end else begin
         int_req_r <= status_ie_s & ~status_exl_s & (|(ip_s & status_im_s));
      end
   end

   assign bus.cp0_Count_data   = count_r;
   assign bus.cp0_Compare_data = compare_r;
   assign bus.cp0_Cause_data   = {bd_r, ti_r, 14'd0, ip_s, 1'b0, exc_code_r, 2'b00};
   assign bus.int_req          = int_req_r;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed self-checking bench for cp0_int_ctrl (COUNT_DIV=2); outputs sampled 1 time unit after posedge.
module tb_cp0_int_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   cp0_int_ctrl_if bus_if ();

   cp0_int_ctrl #(
      .ADDR_COUNT   (6'd9),
      .ADDR_COMPARE (6'd11),
      .ADDR_CAUSE   (6'd13),
      .COUNT_DIV    (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic mtc0(input logic [5:0] addr, input logic [31:0] data);
      bus_if.mtc0_we   = 1'b1;
      bus_if.cp0_addr  = addr;
      bus_if.mtc0_data = data;
      step(1);
      bus_if.mtc0_we   = 1'b0;
      bus_if.cp0_addr  = 6'd0;
      bus_if.mtc0_data = 32'd0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus_if.mtc0_we         = 1'b0;
      bus_if.cp0_addr        = 6'd0;
      bus_if.mtc0_data       = 32'd0;
      bus_if.exception       = 1'b0;
      bus_if.exc_code        = 5'd0;
      bus_if.exc_bd          = 1'b0;
      bus_if.ext_int         = 6'd0;
      bus_if.cp0_Status_data = 32'd0;

      // 1: reset then idle
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("rst_count",   bus_if.cp0_Count_data,   32'd0);
         check("rst_compare", bus_if.cp0_Compare_data, 32'd0);
         check("rst_cause",   bus_if.cp0_Cause_data,   32'd0);
         check("rst_intreq",  {31'd0, bus_if.int_req}, 32'd0);
      end
      rst_n = 1'b1;
      step(20);
      check("idle_count", bus_if.cp0_Count_data, 32'd10);
      check("idle_cause", bus_if.cp0_Cause_data, 32'd0);

      // 2: timer interrupt
      bus_if.cp0_Status_data = 32'h0000_8001;
      mtc0(6'd11, 32'd5);
      check("cmp_load", bus_if.cp0_Compare_data, 32'd5);
      mtc0(6'd9, 32'd0);
      check("cnt_load", bus_if.cp0_Count_data, 32'd0);
      step(9);
      check("cnt_pre_match", bus_if.cp0_Count_data, 32'd4);
      check("ti_pre_match",  bus_if.cp0_Cause_data, 32'd0);
      step(1);
      check("cnt_match",    bus_if.cp0_Count_data, 32'd5);
      check("ti_match",     bus_if.cp0_Cause_data, 32'h4000_8000);
      check("intreq_lag",   {31'd0, bus_if.int_req}, 32'd0);
      step(1);
      check("intreq_timer", {31'd0, bus_if.int_req}, 32'd1);
      mtc0(6'd11, 32'd100);
      check("ti_clear",     bus_if.cp0_Cause_data, 32'd0);
      step(1);
      check("intreq_drop",  {31'd0, bus_if.int_req}, 32'd0);

      // 3: external interrupt through synchronizer
      bus_if.cp0_Status_data = 32'h0000_1001;
      bus_if.ext_int         = 6'b000100;
      step(1);
      check("ext_sync1", bus_if.cp0_Cause_data, 32'd0);
      step(1);
      check("ext_sync2",      bus_if.cp0_Cause_data, 32'h0000_1000);
      check("ext_intreq_lag", {31'd0, bus_if.int_req}, 32'd0);
      step(1);
      check("ext_intreq",     {31'd0, bus_if.int_req}, 32'd1);
      bus_if.cp0_Status_data = 32'h0000_1003;
      step(1);
      check("exl_masks", {31'd0, bus_if.int_req}, 32'd0);
      bus_if.ext_int         = 6'd0;
      bus_if.cp0_Status_data = 32'd0;
      step(2);
      check("ext_cleared", bus_if.cp0_Cause_data, 32'd0);

      // 4: exception capture, BD held while EXL=1
      bus_if.exception = 1'b1;
      bus_if.exc_code  = 5'h0C;
      bus_if.exc_bd    = 1'b1;
      step(1);
      bus_if.exception = 1'b0;
      check("exc_bd_set", bus_if.cp0_Cause_data, 32'h8000_0030);
      bus_if.cp0_Status_data = 32'h0000_0002;
      bus_if.exception = 1'b1;
      bus_if.exc_code  = 5'h08;
      bus_if.exc_bd    = 1'b0;
      step(1);
      bus_if.exception = 1'b0;
      check("exc_bd_hold", bus_if.cp0_Cause_data, 32'h8000_0020);
      bus_if.cp0_Status_data = 32'd0;

      // 5: Count wrap matching Compare=0
      mtc0(6'd11, 32'd0);
      mtc0(6'd9, 32'hFFFF_FFFF);
      step(1);
      check("wrap_pre", bus_if.cp0_Count_data, 32'hFFFF_FFFF);
      check("wrap_ti0", {31'd0, bus_if.cp0_Cause_data[30]}, 32'd0);
      step(1);
      check("wrap_count", bus_if.cp0_Count_data, 32'd0);
      check("wrap_ti1",   {31'd0, bus_if.cp0_Cause_data[30]}, 32'd1);

      // 6: exception blocks MTC0; Compare write beats same-cycle match
      bus_if.exception = 1'b1;
      bus_if.exc_code  = 5'd0;
      bus_if.exc_bd    = 1'b0;
      mtc0(6'd13, 32'h0000_0300);
      bus_if.exception = 1'b0;
      check("exc_blocks_cause", bus_if.cp0_Cause_data, 32'h4000_8000);
      mtc0(6'd13, 32'h0000_0300);
      check("sw_ip_write", bus_if.cp0_Cause_data, 32'h4000_8300);
      bus_if.exception = 1'b1;
      mtc0(6'd9, 32'h0000_4444);
      bus_if.exception = 1'b0;
      check("exc_blocks_count", {31'd0, (bus_if.cp0_Count_data == 32'h0000_4444)}, 32'd0);
      mtc0(6'd11, 32'h0000_0021);
      mtc0(6'd9, 32'h0000_0020);
      step(1);
      check("race_pre_count", bus_if.cp0_Count_data, 32'h0000_0020);
      mtc0(6'd11, 32'h0000_0055);
      check("race_count",   bus_if.cp0_Count_data,   32'h0000_0021);
      check("race_compare", bus_if.cp0_Compare_data, 32'h0000_0055);
      check("race_ti",      {31'd0, bus_if.cp0_Cause_data[30]}, 32'd0);

      // mid-operation reset discards concurrent write and exception
      rst_n                  = 1'b0;
      bus_if.exception       = 1'b1;
      bus_if.exc_code        = 5'h1F;
      bus_if.exc_bd          = 1'b1;
      bus_if.cp0_Status_data = 32'h0000_FF01;
      mtc0(6'd9, 32'h0000_1234);
      bus_if.exception = 1'b0;
      check("mrst_count",   bus_if.cp0_Count_data,   32'd0);
      check("mrst_compare", bus_if.cp0_Compare_data, 32'd0);
      check("mrst_cause",   bus_if.cp0_Cause_data,   32'd0);
      check("mrst_intreq",  {31'd0, bus_if.int_req}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
